rvx_tcm_arbiter: RTL
====================

RVX_TCM_ARBITER -- requirements
Module: rvx_tcm_arbiter

Interface
REQ-001 SHALL have parameter STARVATION_LIMIT, default 4: max consecutive dbus grants while ibus waits (range 1..15).
REQ-002 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports ibus_address in 32, ibus_rrequest in 1, ibus_rdata out 32, ibus_rresponse out 1: instruction read requester.
REQ-005 SHALL have ports dbus_address in 32, dbus_rrequest in 1, dbus_wrequest in 1, dbus_wdata in 32, dbus_wstrobe in 4: data requester command.
REQ-006 SHALL have ports dbus_rdata out 32, dbus_rresponse out 1, dbus_wresponse out 1: data requester responses.
REQ-007 SHALL have ports mem_address out 32, mem_rrequest out 1, mem_wrequest out 1, mem_wdata out 32, mem_wstrobe out 4: shared single-port target command.
REQ-008 SHALL have ports mem_rdata in 32, mem_rresponse in 1, mem_wresponse in 1: target responses.

Function
REQ-009 SHALL implement FSM states IDLE, GRANT_IBUS, GRANT_DBUS.
REQ-010 Requesters SHALL hold request, address, wdata, wstrobe stable until their response; arbiter relies on this.
REQ-011 IDLE: pending request(s) sampled; on rising edge, winner's command registered onto mem_* and FSM moves to GRANT_x; none pending -> stay IDLE, mem requests 0.
REQ-012 Minimum latency: request in cycle 0 -> mem request visible cycle 1.
REQ-013 GRANT_x: mem_* held constant until matching target response (mem_rresponse for reads, mem_wresponse for writes).
REQ-014 Responses routed combinationally: granted port's response = matching mem response while in its GRANT state; other port's responses 0.
REQ-015 mem_rdata SHALL drive both ibus_rdata and dbus_rdata unmodified; valid only with respective rresponse.
REQ-016 On matching response edge FSM returns to IDLE; mem requests 0 next cycle; back-to-back transaction costs one IDLE cycle.
REQ-017 Non-matching target response (e.g. mem_wresponse during read) SHALL be ignored.
REQ-018 dbus_rrequest and dbus_wrequest both high: treated as write only; no dbus_rresponse generated.
REQ-019 Default arbitration: dbus wins over ibus when both pending in IDLE.
REQ-020 4-bit starvation counter: +1 per dbus grant while ibus_rrequest high; cleared on ibus grant or when ibus_rrequest low in IDLE.
REQ-021 Counter == STARVATION_LIMIT in IDLE with both pending: ibus wins.
REQ-022 Read grant: mem_wdata, mem_wstrobe = 0; write grant: mem_wdata/mem_wstrobe = dbus values.

Reset
REQ-023 reset_n low: FSM IDLE, counter 0, mem_address/mem_wdata 0, mem_wstrobe 0, mem_rrequest/mem_wrequest 0, all responses 0, effective immediately (async).
REQ-024 Reset mid-transaction: in-flight transaction abandoned; late target response after deassertion ignored (FSM in IDLE).
REQ-025 First grant possible on first rising edge after reset_n deasserts.

Configuration
REQ-026 Macro RVX_TCM_ARBITER_ROUND_ROBIN_EN defined: round-robin; last-granted requester loses when both pending; starvation counter and STARVATION_LIMIT unused.
REQ-027 Macro undefined: fixed dbus priority with starvation limit per REQ-019..021.
REQ-028 Interface identical in both configurations.

Verification
REQ-029 Single ibus read 0x00000100, target returns 0x00000013 after 1 cycle -> mem_rrequest in cycle 1, ibus_rresponse with ibus_rdata=0x00000013 in cycle 2, dbus responses 0.
REQ-030 Simultaneous ibus read 0x0 and dbus write 0x1000 data 0x1 strobe 0xF (default config) -> write granted first (mem_wdata=0x1, mem_wstrobe=0xF), ibus read granted after IDLE cycle.
REQ-031 dbus reads continuously, ibus pending, STARVATION_LIMIT=4 -> exactly 4 dbus grants then ibus granted; counter 0 afterwards.
REQ-032 With RVX_TCM_ARBITER_ROUND_ROBIN_EN, both continuously requesting -> grants alternate dbus, ibus, dbus, ibus.
REQ-033 reset_n pulled low while GRANT_DBUS, target response after reset release -> all mem outputs 0 immediately, stray response produces no dbus_rresponse/dbus_wresponse.
REQ-034 Random target latency 1..8 cycles with random requests, 10000 cycles -> each request gets exactly one response, mem_* stable during every grant, no requester's data misrouted.

Source files
------------

// File: rtl/rvx_tcm_arbiter.sv
// rvx_tcm_arbiter: arbitrates an instruction read port (ibus) and a data
// read/write port (dbus) onto one single-port tightly-coupled memory.
// One transaction is outstanding at a time. The command is registered onto
// mem_* at grant and held until the matching target response. Responses are
// routed back combinationally.
// Default build: dbus has fixed priority, bounded by a starvation counter
// that hands ibus the memory after STARVATION_LIMIT consecutive dbus grants.
// Optional macro RVX_TCM_ARBITER_ROUND_ROBIN_EN: the requester granted last
// loses when both are pending, and the starvation counter is not built.
module rvx_tcm_arbiter #(
    parameter int unsigned STARVATION_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    // instruction read requester
    input  logic [31:0] ibus_address,
    input  logic        ibus_rrequest,
    output logic [31:0] ibus_rdata,
    output logic        ibus_rresponse,
    // data requester
    input  logic [31:0] dbus_address,
    input  logic        dbus_rrequest,
    input  logic        dbus_wrequest,
    input  logic [31:0] dbus_wdata,
    input  logic [3:0]  dbus_wstrobe,
    output logic [31:0] dbus_rdata,
    output logic        dbus_rresponse,
    output logic        dbus_wresponse,
    // shared target
    output logic [31:0] mem_address,
    output logic        mem_rrequest,
    output logic        mem_wrequest,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrobe,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rresponse,
    input  logic        mem_wresponse
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_IBUS = 2'd1,
        GRANT_DBUS = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic        mem_rrequest_q, mem_rrequest_d;
    logic        mem_wrequest_q, mem_wrequest_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrobe_q, mem_wstrobe_d;

`ifdef RVX_TCM_ARBITER_ROUND_ROBIN_EN
    // 1 when dbus held the most recent grant; reset favours dbus first
    logic        last_dbus_q, last_dbus_d;
`else
    localparam logic [3:0] LIMIT = 4'(STARVATION_LIMIT);
    logic [3:0]  starve_q, starve_d;
`endif

    logic ibus_pend;
    logic dbus_pend;
    logic pick_dbus;
    logic dbus_done;

    assign ibus_pend = ibus_rrequest;
    assign dbus_pend = dbus_rrequest | dbus_wrequest;
    // a dbus grant finishes on the response that matches its command type
    assign dbus_done = mem_wrequest_q ? mem_wresponse : mem_rresponse;

`ifdef RVX_TCM_ARBITER_ROUND_ROBIN_EN
    assign pick_dbus = dbus_pend && !(ibus_pend && last_dbus_q);
`else
    assign pick_dbus = dbus_pend && !(ibus_pend && (starve_q >= LIMIT));
`endif

    // next-state, grant decision and command capture
    always_comb begin
        state_d        = state_q;
        mem_address_d  = mem_address_q;
        mem_rrequest_d = mem_rrequest_q;
        mem_wrequest_d = mem_wrequest_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wstrobe_d  = mem_wstrobe_q;
`ifdef RVX_TCM_ARBITER_ROUND_ROBIN_EN
        last_dbus_d    = last_dbus_q;
`else
        starve_d       = starve_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_dbus) begin
                    state_d       = GRANT_DBUS;
                    mem_address_d = dbus_address;
                    if (dbus_wrequest) begin
                        // a simultaneous read request is dropped: write only
                        mem_rrequest_d = 1'b0;
                        mem_wrequest_d = 1'b1;
                        mem_wdata_d    = dbus_wdata;
                        mem_wstrobe_d  = dbus_wstrobe;
                    end else begin
                        mem_rrequest_d = 1'b1;
                        mem_wrequest_d = 1'b0;
                        mem_wdata_d    = 32'd0;
                        mem_wstrobe_d  = 4'd0;
                    end
`ifdef RVX_TCM_ARBITER_ROUND_ROBIN_EN
                    last_dbus_d = 1'b1;
`else
                    if (!ibus_pend) begin
                        starve_d = 4'd0;
                    end else if (starve_q != 4'hF) begin
                        starve_d = starve_q + 4'd1;
                    end
`endif
                end else if (ibus_pend) begin
                    state_d        = GRANT_IBUS;
                    mem_address_d  = ibus_address;
                    mem_rrequest_d = 1'b1;
                    mem_wrequest_d = 1'b0;
                    mem_wdata_d    = 32'd0;
                    mem_wstrobe_d  = 4'd0;
`ifdef RVX_TCM_ARBITER_ROUND_ROBIN_EN
                    last_dbus_d = 1'b0;
`else
                    starve_d = 4'd0;
`endif
                end else begin
`ifndef RVX_TCM_ARBITER_ROUND_ROBIN_EN
                    starve_d = 4'd0;
`endif
                end
            end
            GRANT_IBUS: begin
                if (mem_rresponse) begin
                    state_d        = IDLE;
                    mem_rrequest_d = 1'b0;
                    mem_wrequest_d = 1'b0;
                end
            end
            GRANT_DBUS: begin
                if (dbus_done) begin
                    state_d        = IDLE;
                    mem_rrequest_d = 1'b0;
                    mem_wrequest_d = 1'b0;
                end
            end
            default: begin
                state_d        = IDLE;
                mem_rrequest_d = 1'b0;
                mem_wrequest_d = 1'b0;
            end
        endcase
    end

    // state and command registers, cleared asynchronously by reset_n
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            mem_address_q  <= 32'd0;
            mem_rrequest_q <= 1'b0;
            mem_wrequest_q <= 1'b0;
            mem_wdata_q    <= 32'd0;
            mem_wstrobe_q  <= 4'd0;
`ifdef RVX_TCM_ARBITER_ROUND_ROBIN_EN
            last_dbus_q    <= 1'b0;
`else
            starve_q       <= 4'd0;
`endif
        end else begin
            state_q        <= state_d;
            mem_address_q  <= mem_address_d;
            mem_rrequest_q <= mem_rrequest_d;
            mem_wrequest_q <= mem_wrequest_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wstrobe_q  <= mem_wstrobe_d;
`ifdef RVX_TCM_ARBITER_ROUND_ROBIN_EN
            last_dbus_q    <= last_dbus_d;
`else
            starve_q       <= starve_d;
`endif
        end
    end

    assign mem_address  = mem_address_q;
    assign mem_rrequest = mem_rrequest_q;
    assign mem_wrequest = mem_wrequest_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wstrobe  = mem_wstrobe_q;

    // read data is shared; only the granted port sees a response strobe
    assign ibus_rdata     = mem_rdata;
    assign dbus_rdata     = mem_rdata;
    assign ibus_rresponse = (state_q == GRANT_IBUS) && mem_rresponse;
    assign dbus_rresponse = (state_q == GRANT_DBUS) && mem_rrequest_q && mem_rresponse;
    assign dbus_wresponse = (state_q == GRANT_DBUS) && mem_wrequest_q && mem_wresponse;

endmodule
